// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the shifter arbiter: operand/amount widths, shifter
// opcode encodings, the per-port request bundle and the response-register
// state encoding.
// ---------------------------------------------------------------------------
package shift_pkg;

    localparam int SH_W     = 16;
    localparam int SH_AMT_W = 4;
    localparam int SH_OP_W  = 3;

    // Shifter decodes op[1] first (ROR), then op[0] (SRA), else SLL, so the
    // remaining five encodings alias onto these three.
    localparam logic [SH_OP_W-1:0] SH_OP_SLL = 3'b000;
    localparam logic [SH_OP_W-1:0] SH_OP_SRA = 3'b001;
    localparam logic [SH_OP_W-1:0] SH_OP_ROR = 3'b010;

    typedef struct packed {
        logic [SH_W-1:0]     data;
        logic [SH_AMT_W-1:0] amt;
        logic [SH_OP_W-1:0]  op;
    } sh_req_t;

    // Response register occupancy.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } resp_state_t;

endpackage

// File: rtl/shift_arb_pick.sv
// ---------------------------------------------------------------------------
// shift_arb_pick
// Combinational two-port picker.
//   valid[1:0]  in  : per-port request valid
//   last        in  : last-served port (round-robin pointer)
//   grant_idx   out : index of the winning port (meaningful when grant_any)
//   grant_any   out : at least one port is requesting
// Build option: SHIFT_ARB_RR_EN defined selects round-robin on contention;
// undefined gives fixed priority with port 0 always winning and `last`
// ignored.
// ---------------------------------------------------------------------------
module shift_arb_pick (
    input  logic [1:0] valid,
    input  logic       last,
    output logic       grant_idx,
    output logic       grant_any
);

    assign grant_any = |valid;

`ifdef SHIFT_ARB_RR_EN
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    always_comb begin
        grant_idx = 1'b0;
        if (valid == 2'b11) begin
            grant_idx = ~last;
        end else begin
            grant_idx = valid[1];
        end
    end
`else
    // Port 1 wins only when port 0 is idle.
    assign grant_idx = valid[1] & ~valid[0];

    logic last_unused;
    assign last_unused = last;
`endif

endmodule

// File: rtl/shift_arb.sv
// ---------------------------------------------------------------------------
// shift_arb
// Shares one external combinational 16-bit shifter between two requesters
// (port 0: ALU path, port 1: auxiliary path). One request is granted per
// cycle, its fields drive the shifter, and the shifter result is captured in
// a one-entry response register returned under valid/ready.
//
// Ports
//   clk, rst_n                      : clock, async active-low reset
//   req_valid[1:0] / req_ready[1:0] : per-port request handshake
//   req_data0/1, req_amt0/1, req_op0/1 : per-port request fields
//   sh_in, sh_amt, sh_op            : drive the shared shifter (0 when idle)
//   sh_out, sh_z                    : shifter result and zero flag
//   resp_valid / resp_ready         : response handshake
//   resp_id, resp_data, resp_z      : held result and issuing port
//
// Build option: SHIFT_ARB_RR_EN enables round-robin arbitration through the
// `last` register (reset to RR_INIT). Without it port 0 has fixed priority,
// `last` is not built and RR_INIT is ignored.
// ---------------------------------------------------------------------------
import shift_pkg::*;

module shift_arb #(
    parameter logic RR_INIT = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [SH_W-1:0]     req_data0,
    input  logic [SH_AMT_W-1:0] req_amt0,
    input  logic [SH_OP_W-1:0]  req_op0,
    input  logic [SH_W-1:0]     req_data1,
    input  logic [SH_AMT_W-1:0] req_amt1,
    input  logic [SH_OP_W-1:0]  req_op1,
    output logic [SH_W-1:0]     sh_in,
    output logic [SH_AMT_W-1:0] sh_amt,
    output logic [SH_OP_W-1:0]  sh_op,
    input  logic [SH_W-1:0]     sh_out,
    input  logic                sh_z,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_id,
    output logic [SH_W-1:0]     resp_data,
    output logic                resp_z
);

    sh_req_t     req0, req1, sel_req;
    logic        grant_idx, grant_any, grant_ok;
    logic        slot_free, accept;
    logic        last_q;

    resp_state_t     state_q, state_d;
    logic [SH_W-1:0] resp_data_q, resp_data_d;
    logic            resp_z_q, resp_z_d;
    logic            resp_id_q, resp_id_d;

    assign req0 = '{data: req_data0, amt: req_amt0, op: req_op0};
    assign req1 = '{data: req_data1, amt: req_amt1, op: req_op1};

    shift_arb_pick u_pick (
        .valid     (req_valid),
        .last      (last_q),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Grants are suppressed while reset is asserted so a requester never sees
    // a handshake that the held-in-reset registers cannot honour.
    assign grant_ok  = grant_any & rst_n;
    assign slot_free = (state_q == ST_EMPTY) | resp_ready;
    assign accept    = grant_ok & slot_free;

    // Shifter input mux: idle cycles drive zeros rather than a stale port.
    always_comb begin
        sel_req = '0;
        if (grant_ok) begin
            sel_req = grant_idx ? req1 : req0;
        end
    end

    assign sh_in  = sel_req.data;
    assign sh_amt = sel_req.amt;
    assign sh_op  = sel_req.op;

    always_comb begin
        req_ready = 2'b00;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Response register next state: a load wins over a drain, which gives
    // back-to-back throughput when drain and accept coincide.
    always_comb begin
        state_d     = state_q;
        resp_data_d = resp_data_q;
        resp_z_d    = resp_z_q;
        resp_id_d   = resp_id_q;
        if (accept) begin
            state_d     = ST_FULL;
            resp_data_d = sh_out;
            resp_z_d    = sh_z;
            resp_id_d   = grant_idx;
        end else if ((state_q == ST_FULL) && resp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples its _d value from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            resp_data_q <= '0;
            resp_z_q    <= 1'b0;
            resp_id_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            resp_data_q <= resp_data_d;
            resp_z_q    <= resp_z_d;
            resp_id_q   <= resp_id_d;
        end
    end

`ifdef SHIFT_ARB_RR_EN
    logic last_d;

    assign last_d = accept ? grant_idx : last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= RR_INIT;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Fixed priority: the picker ignores `last`, so no register is built.
    logic rr_init_unused;
    assign rr_init_unused = RR_INIT;
    assign last_q         = 1'b0;
`endif

    assign resp_valid = (state_q == ST_FULL);
    assign resp_data  = resp_data_q;
    assign resp_z     = resp_z_q;
    assign resp_id    = resp_id_q;

endmodule
